// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the decode-stage hazard
//               controller. It holds the controller state encoding, the
//               architectural register count and a one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ECALL = 2'd2
  } hazard_state_t;

  // Returns a one-hot mask that selects register idx. Bit 0 (x0) is never
  // busy, so masking it has no effect.
  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [REG_COUNT-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Register write-pending scoreboard. There is one bit per
//               architectural register. A set and a clear aimed at the same
//               register in the same cycle leave the bit set, because the new
//               writer is younger than the one that is retiring. x0 is
//               hard-wired to 0.
// Ports       : clk        rising-edge clock
//               reset      synchronous active-high reset (clears all bits)
//               set_valid  mark set_reg as pending at the next edge
//               set_reg    register to mark
//               clr_valid  clear clr_reg at the next edge
//               clr_reg    register to clear
//               busy_regs  pending-write vector, bit n = xn
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import pipeline_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [REG_IDX_W-1:0] set_reg,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_reg,
  output logic [REG_COUNT-1:0] busy_regs
);

  assign busy_regs[0] = 1'b0;

  for (genvar n = 1; n < REG_COUNT; n++) begin : g_bit
    logic busy_q;

    // Set is tested before clear so that set wins on a collision.
    always_ff @(posedge clk) begin
      if (reset) begin
        busy_q <= 1'b0;
      end else if (set_valid && (set_reg == REG_IDX_W'(n))) begin
        busy_q <= 1'b1;
      end else if (clr_valid && (clr_reg == REG_IDX_W'(n))) begin
        busy_q <= 1'b0;
      end
    end

    assign busy_regs[n] = busy_q;
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Decode-stage hazard controller. It stalls on RAW and WAW
//               hazards against a register scoreboard, limits the number of
//               instructions in flight, and serialises ECALL. An ECALL first
//               drains the pipeline and then holds ecall_req until the handler
//               reports ecall_done.
// Config      : HAZARD_RETIRE_BYPASS_EN - when defined, a register that
//               retires this cycle counts as free in the hazard check, which
//               removes one stall cycle.
// Ports       : clk, reset                 clock / sync active-high reset
//               dec_valid, dec_r1_reg, dec_r2_reg, dec_dst_reg, dec_ecall
//                                          decoded instruction
//               next_stage_ready           execute stage can accept
//               retire_valid, retire_dst_reg  writeback retirement
//               flush                      squash instruction in decode
//               ecall_done                 system-call handler finished
//               issue_valid, dec_ready     issue / decode-advance strobes
//               ecall_req                  drained, ECALL being serviced
//               busy_regs                  scoreboard
//               inflight_cnt               issued-but-unretired count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_r1_reg,
  input  logic [REG_IDX_W-1:0] dec_r2_reg,
  input  logic [REG_IDX_W-1:0] dec_dst_reg,
  input  logic                 dec_ecall,
  input  logic                 next_stage_ready,
  input  logic                 retire_valid,
  input  logic [REG_IDX_W-1:0] retire_dst_reg,
  input  logic                 flush,
  input  logic                 ecall_done,
  output logic                 issue_valid,
  output logic                 dec_ready,
  output logic                 ecall_req,
  output logic [REG_COUNT-1:0] busy_regs,
  output logic [CNT_W-1:0]     inflight_cnt
);

  hazard_state_t        state;
  hazard_state_t        state_next;
  logic [CNT_W-1:0]     cnt_next;
  logic [REG_COUNT-1:0] busy_eff;
  logic                 hazard;
  logic                 has_room;
  logic                 retire_ok;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
`ifdef HAZARD_RETIRE_BYPASS_EN
  // A register that retires this cycle is already written back, so it is
  // treated as free now rather than after the scoreboard updates.
  assign busy_eff = retire_valid ? (busy_regs & ~reg_onehot(retire_dst_reg)) : busy_regs;
`else
  assign busy_eff = busy_regs;
`endif

  assign hazard = ((dec_r1_reg  != '0) && busy_eff[dec_r1_reg])  ||
                  ((dec_r2_reg  != '0) && busy_eff[dec_r2_reg])  ||
                  ((dec_dst_reg != '0) && busy_eff[dec_dst_reg]);

  assign has_room = (inflight_cnt < CNT_W'(MAX_INFLIGHT));

  // The reset term holds the strobes low while reset is asserted, even though
  // the registered state has not yet returned to IDLE.
  assign issue_valid = !reset && dec_valid && !dec_ecall && !hazard && !flush &&
                       (state == IDLE) && has_room && next_stage_ready;

  assign dec_ready = !reset &&
                     (issue_valid || flush || ((state == ECALL) && ecall_done));

  assign ecall_req = !reset && (state == ECALL);

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (issue_valid && (dec_dst_reg != '0)),
    .set_reg   (dec_dst_reg),
    .clr_valid (retire_valid),
    .clr_reg   (retire_dst_reg),
    .busy_regs (busy_regs)
  );

  // --------------------------------------------------------------------------
  // In-flight counter
  // --------------------------------------------------------------------------
  // A spurious retire with nothing in flight is dropped so the count cannot
  // wrap.
  assign retire_ok = retire_valid && (inflight_cnt != '0);

  always_comb begin
    cnt_next = inflight_cnt;
    case ({issue_valid, retire_ok})
      2'b10:   cnt_next = inflight_cnt + CNT_W'(1);
      2'b01:   cnt_next = inflight_cnt - CNT_W'(1);
      default: cnt_next = inflight_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_cnt <= '0;
    end else begin
      inflight_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(retire_valid && (inflight_cnt == '0)))
        else $warning("pipeline_hazard_ctrl: retire with no instruction in flight");
    end
  end

  // --------------------------------------------------------------------------
  // ECALL serialisation FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dec_valid && dec_ecall && !flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Compare against the next count so that the last retire moves us on
        // in the same cycle. Nothing issues in DRAIN, so only retires reach
        // cnt_next here.
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_next == '0) begin
          state_next = ECALL;
        end
      end
      ECALL: begin
        if (ecall_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl
//               (MAX_INFLIGHT = 8). It covers scoreboard stalls, counter
//               limits, the ECALL drain/flush paths and reset priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [4:0]       dec_r1_reg;
  logic [4:0]       dec_r2_reg;
  logic [4:0]       dec_dst_reg;
  logic             dec_ecall;
  logic             next_stage_ready;
  logic             retire_valid;
  logic [4:0]       retire_dst_reg;
  logic             flush;
  logic             ecall_done;
  logic             issue_valid;
  logic             dec_ready;
  logic             ecall_req;
  logic [31:0]      busy_regs;
  logic [CNT_W-1:0] inflight_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dec_valid        (dec_valid),
    .dec_r1_reg       (dec_r1_reg),
    .dec_r2_reg       (dec_r2_reg),
    .dec_dst_reg      (dec_dst_reg),
    .dec_ecall        (dec_ecall),
    .next_stage_ready (next_stage_ready),
    .retire_valid     (retire_valid),
    .retire_dst_reg   (retire_dst_reg),
    .flush            (flush),
    .ecall_done       (ecall_done),
    .issue_valid      (issue_valid),
    .dec_ready        (dec_ready),
    .ecall_req        (ecall_req),
    .busy_regs        (busy_regs),
    .inflight_cnt     (inflight_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid        = 1'b0;
    dec_r1_reg       = 5'd0;
    dec_r2_reg       = 5'd0;
    dec_dst_reg      = 5'd0;
    dec_ecall        = 1'b0;
    next_stage_ready = 1'b1;
    retire_valid     = 1'b0;
    retire_dst_reg   = 5'd0;
    flush            = 1'b0;
    ecall_done       = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    clear_inputs();
    reset = 1'b1; dec_valid = 1'b1; flush = 1'b1; ecall_done = 1'b1;
    #1;
    check("rst_issue", issue_valid, 0);
    check("rst_dec_ready", dec_ready, 0);
    check("rst_ecall_req", ecall_req, 0);
    step(); step();
    check("rst_busy", busy_regs, 0);
    check("rst_cnt", inflight_cnt, 0);
    clear_inputs();
    reset = 1'b0;
    #1;
    check("post_rst_issue", issue_valid, 0);

    // ---------------- RAW stall on x5 ----------------
    dec_valid = 1'b1; dec_dst_reg = 5'd5;
    #1;
    check("issue_x5", issue_valid, 1);
    check("issue_x5_ready", dec_ready, 1);
    step();
    check("busy_x5", busy_regs, 32'h20);
    check("cnt_1", inflight_cnt, 1);
    dec_r1_reg = 5'd5; dec_dst_reg = 5'd6;
    #1;
    check("raw_stall_0", issue_valid, 0);
    step();
    check("raw_stall_1", issue_valid, 0);
    check("raw_busy_hold", busy_regs, 32'h20);
    retire_valid = 1'b1; retire_dst_reg = 5'd5;
    #1;
`ifdef HAZARD_RETIRE_BYPASS_EN
    check("bypass_issue", issue_valid, 1);
    step();
    retire_valid = 1'b0;
    #1;
`else
    check("nobypass_stall", issue_valid, 0);
    step();
    retire_valid = 1'b0;
    #1;
    check("nobypass_busy", busy_regs, 0);
    check("nobypass_cnt", inflight_cnt, 0);
    check("nobypass_issue", issue_valid, 1);
    step();
`endif
    check("after_raw_busy", busy_regs, 32'h40);
    check("after_raw_cnt", inflight_cnt, 1);
    clear_inputs();
    retire_valid = 1'b1; retire_dst_reg = 5'd6;
    step();
    retire_valid = 1'b0;
    #1;
    check("drain_x6_busy", busy_regs, 0);
    check("drain_x6_cnt", inflight_cnt, 0);

    // ---------------- in-flight limit ----------------
    dec_valid = 1'b1;
    repeat (8) step();
    check("full_cnt", inflight_cnt, 8);
    check("full_blocks", issue_valid, 0);
    check("full_no_ready", dec_ready, 0);
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    #1;
    check("retire_cnt_7", inflight_cnt, 7);
    check("resume_issue", issue_valid, 1);
    retire_valid = 1'b1;
    step();
    check("issue_retire_cnt", inflight_cnt, 7);
    retire_valid = 1'b0; next_stage_ready = 1'b0;
    #1;
    check("not_ready_blocks", issue_valid, 0);
    next_stage_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_blocks", issue_valid, 0);
    check("flush_dec_ready", dec_ready, 1);
    flush = 1'b0; dec_valid = 1'b0; retire_valid = 1'b1;
    repeat (7) step();
    retire_valid = 1'b0;
    #1;
    check("empty_cnt", inflight_cnt, 0);

    // ---------------- ECALL drain with 3 in flight ----------------
    dec_valid = 1'b1;
    repeat (3) step();
    check("ecall_pre_cnt", inflight_cnt, 3);
    dec_ecall = 1'b1;
    #1;
    check("ecall_no_issue", issue_valid, 0);
    check("ecall_no_ready", dec_ready, 0);
    step();
    check("drain_no_req", ecall_req, 0);
    retire_valid = 1'b1;
    step();
    check("drain_r1_req", ecall_req, 0);
    check("drain_r1_cnt", inflight_cnt, 2);
    step();
    check("drain_r2_req", ecall_req, 0);
    step();
    check("drain_done_req", ecall_req, 1);
    check("drain_done_cnt", inflight_cnt, 0);
    retire_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("ecall_ignores_flush", ecall_req, 1);
    ecall_done = 1'b1;
    #1;
    check("ecall_done_ready", dec_ready, 1);
    step();
    ecall_done = 1'b0; dec_valid = 1'b0; dec_ecall = 1'b0;
    #1;
    check("ecall_exit_req", ecall_req, 0);
    check("ecall_exit_ready", dec_ready, 0);

    // ---------------- ECALL cancelled by flush in DRAIN ----------------
    dec_valid = 1'b1;
    step();
    dec_ecall = 1'b1;
    step();
    check("flushdrain_req0", ecall_req, 0);
    flush = 1'b1;
    #1;
    check("flushdrain_ready", dec_ready, 1);
    check("flushdrain_issue", issue_valid, 0);
    step();
    flush = 1'b0; dec_ecall = 1'b0;
    #1;
    check("flushdrain_idle_issue", issue_valid, 1);
    check("flushdrain_req1", ecall_req, 0);
    check("flushdrain_cnt", inflight_cnt, 1);
    dec_valid = 1'b0; retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    #1;
    check("flushdrain_req2", ecall_req, 0);
    check("flushdrain_empty", inflight_cnt, 0);

    // ---------------- set/clear collision, spurious retire ----------------
    dec_valid = 1'b1;
    step();
    dec_dst_reg = 5'd7; retire_valid = 1'b1; retire_dst_reg = 5'd7;
    #1;
    check("collide_issue", issue_valid, 1);
    step();
    check("collide_busy", busy_regs, 32'h80);
    check("collide_cnt", inflight_cnt, 1);
    dec_valid = 1'b0; dec_dst_reg = 5'd0;
    step();
    check("x7_retired_busy", busy_regs, 0);
    check("x7_retired_cnt", inflight_cnt, 0);
    step();
    retire_valid = 1'b0;
    #1;
    check("underflow_cnt", inflight_cnt, 0);

    // ---------------- reset during ECALL ----------------
    dec_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      dec_dst_reg = 5'(i);
      step();
    end
    check("fill_busy", busy_regs, 32'hFE);
    check("fill_cnt", inflight_cnt, 7);
    dec_dst_reg = 5'd0; dec_ecall = 1'b1;
    step();
    dec_valid = 1'b0; dec_ecall = 1'b0;
    retire_valid = 1'b1; retire_dst_reg = 5'd0;
    repeat (7) step();
    retire_valid = 1'b0;
    #1;
    check("pre_rst_req", ecall_req, 1);
    check("pre_rst_busy", busy_regs, 32'hFE);
    reset = 1'b1; flush = 1'b1; dec_valid = 1'b1;
    #1;
    check("midrst_issue", issue_valid, 0);
    check("midrst_ready", dec_ready, 0);
    check("midrst_req", ecall_req, 0);
    step();
    reset = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    #1;
    check("postrst_busy", busy_regs, 0);
    check("postrst_cnt", inflight_cnt, 0);
    check("postrst_req", ecall_req, 0);
    check("postrst_ready", dec_ready, 0);
    dec_valid = 1'b1;
    #1;
    check("postrst_idle_issue", issue_valid, 1);
    dec_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
